// File: rtl/maj3_lane_pipe.sv
// maj3_lane_pipe
//   Elastic multi-lane pipeline that evaluates a three-input bitwise function
//   (majority, mux, and-or, xor3) on CH independent W-bit lanes and carries
//   the result through DEPTH registered stages with valid/ready flow control.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           synchronous clear of every stage valid bit
//   in_valid/ready  input handshake; in_mode selects the function for the beat
//   in_a/b/c        operands, lane k at [k*W +: W]
//   in_kill         per-lane force-to-zero
//   out_valid/ready output handshake
//   out_data        per-lane result
//   out_nz          per-lane non-zero flag, registered with the data
//   acc_cnt         saturating count of accepted input beats (flush keeps it)
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. The producer holds valid and its payload until that edge; ready may
// depend combinationally on downstream ready but never on valid.
module maj3_lane_pipe #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [CH*W-1:0]   in_a,
  input  logic [CH*W-1:0]   in_b,
  input  logic [CH*W-1:0]   in_c,
  input  logic [CH-1:0]     in_kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*W-1:0]   out_data,
  output logic [CH-1:0]     out_nz,
  output logic [15:0]       acc_cnt
);

  function automatic logic [W-1:0] lane_fn(input logic [1:0] m,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    case (m)
      2'd0:    return (a & b) | (a & c) | (b & c);
      2'd1:    return (c & a) | (~c & b);
      2'd2:    return (a & b) | c;
      default: return a ^ b ^ c;
    endcase
  endfunction

  logic [CH*W-1:0] f_data;
  logic [CH-1:0]   f_nz;

  always_comb begin
    f_data = '0;
    f_nz   = '0;
    for (int k = 0; k < CH; k++) begin
      if (!in_kill[k]) begin
        f_data[k*W +: W] = lane_fn(in_mode, in_a[k*W +: W], in_b[k*W +: W], in_c[k*W +: W]);
      end
      f_nz[k] = |f_data[k*W +: W];
    end
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ld;
  logic [CH*W-1:0]  d  [DEPTH];
  logic [CH-1:0]    nz [DEPTH];
  logic             in_fire;

  // Stage s can load when it or any stage after it is empty, or when the
  // output is being consumed: the ready chain collapses to an OR over the
  // downstream valid bits, so no combinational loop through the stages.
  always_comb begin
    ld = '0;
    for (int s = 0; s < DEPTH; s++) begin
      ld[s] = out_ready;
      for (int j = s; j < DEPTH; j++) begin
        if (!v[j]) ld[s] = 1'b1;
      end
    end
  end

  assign in_ready = rst_n & ~flush & ld[0];
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      acc_cnt <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        d[s]  <= '0;
        nz[s] <= '0;
      end
    end else begin
      if (flush)      v[0] <= 1'b0;
      else if (ld[0]) v[0] <= in_fire;
      if (in_fire) begin
        d[0]  <= f_data;
        nz[0] <= f_nz;
      end
      for (int s = 1; s < DEPTH; s++) begin
        if (flush)      v[s] <= 1'b0;
        else if (ld[s]) v[s] <= v[s-1];
        // Only real beats overwrite data; a bubble moving in leaves it alone.
        if (ld[s] && v[s-1]) begin
          d[s]  <= d[s-1];
          nz[s] <= nz[s-1];
        end
      end
      if (in_fire && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_nz    = nz[DEPTH-1];

endmodule

// File: tb/tb_maj3_lane_pipe.sv
// Directed bench for maj3_lane_pipe (CH=4, W=8, DEPTH=2).
module tb_maj3_lane_pipe;
  localparam int CH    = 4;
  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int DW    = CH * W;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_a, in_b, in_c;
  logic [CH-1:0] in_kill;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CH-1:0] out_nz;
  logic [15:0]   acc_cnt;

  maj3_lane_pipe #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_kill(in_kill),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nz(out_nz), .acc_cnt(acc_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected {nz, data} per accepted beat, in order
  logic [DW+CH-1:0] exp_q[$];
  int               occ = 0;
  logic [15:0]      acc_exp = '0;
  logic             held_pending = 1'b0;
  logic [DW+CH-1:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ          = 0;
      acc_exp      = '0;
      held_pending = 1'b0;
    end else begin
      check("acc_cnt", acc_cnt, acc_exp);
      check("in_ready", in_ready, (!flush && (occ < DEPTH || out_ready)));
      if (held_pending && out_valid) check("stall_hold", {out_nz, out_data}, held);
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("out_beat", {out_nz, out_data}, exp_q.pop_front());
      end
      held_pending = out_valid && !out_ready;
      held         = {out_nz, out_data};
      if (in_valid && in_ready && acc_exp != 16'hFFFF) acc_exp = acc_exp + 16'd1;
      if (flush) occ = 0;
      else occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  // driver: offer one beat, wait (bounded) for acceptance, record expectation
  task automatic send(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input logic [CH-1:0] k,
                      input logic [DW+CH-1:0] exp);
    logic got;
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_kill  = k;
    got      = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("send_accept", got, 1'b1);
    if (got) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] A0 = {4{8'hF0}};
  localparam logic [DW-1:0] B0 = {4{8'hCC}};
  localparam logic [DW-1:0] C0 = {4{8'hAA}};

  logic [DW-1:0] burst_b  [8] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF01,
                                  32'h00FF00FF, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
  logic [CH-1:0] burst_nz [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h5, 4'hF, 4'hF, 4'hF};
  bit            burst_done;
  logic [15:0]   acc_hold;
  int            n_fill;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_mode = 2'd0;
    in_a = A0; in_b = B0; in_c = C0; in_kill = '0; out_ready = 1'b1;

    // reset values
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_nz", out_nz, '0);
    check("rst_acc", acc_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);

    // first beat: majority, latency
    send(2'd0, A0, B0, C0, 4'h0, {4'hF, {4{8'hE8}}});
    @(negedge clk);
    check("lat_not_yet", out_valid, 1'b0);
    check("acc_one", acc_cnt, 16'd1);
    @(negedge clk);
    check("lat_valid", out_valid, 1'b1);
    check("maj_data", out_data, {4{8'hE8}});
    check("maj_nz", out_nz, 4'hF);
    idle(1);

    // the other modes, kill, distinct lanes, all-zero result
    send(2'd1, A0, B0, C0, 4'h0, {4'hF, {4{8'hE4}}});
    send(2'd2, A0, B0, C0, 4'h0, {4'hF, {4{8'hEA}}});
    send(2'd3, A0, B0, C0, 4'h0, {4'hF, {4{8'h96}}});
    send(2'd0, A0, B0, C0, 4'b0101, {4'b1010, 32'hE800E800});
    send(2'd0, 32'h00FF0F55, 32'h0F0FFF33, 32'hFF00F00F, 4'h0, {4'hF, 32'h0F0FFF17});
    send(2'd3, 32'h0, 32'h0, 32'h0, 4'h0, {4'h0, 32'h0});
    idle(4);
    check("drain_modes", exp_q.size(), 0);

    // back-to-back burst with out_ready pattern 1,0,0
    burst_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(2'd1, {DW{1'b1}}, burst_b[i], '0, 4'h0, {burst_nz[i], burst_b[i]});
        burst_done = 1'b1;
      end
      begin
        int j = 0;
        while (!burst_done) begin
          out_ready = (j % 3 == 0);
          j++;
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    idle(5);
    check("drain_burst", exp_q.size(), 0);

    // fill, then flush with a beat offered
    out_ready = 1'b0;
    send(2'd0, A0, B0, C0, 4'h0, {4'hF, {4{8'hE8}}});
    send(2'd2, A0, B0, C0, 4'h0, {4'hF, {4{8'hEA}}});
    @(negedge clk);
    check("fill_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    acc_hold = acc_exp;
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_acc", acc_cnt, acc_hold);
    exp_q.delete();
    out_ready = 1'b1;
    idle(1);
    send(2'd3, A0, B0, C0, 4'h0, {4'hF, {4{8'h96}}});
    idle(4);
    check("drain_flush", exp_q.size(), 0);

    // saturation of acc_cnt
    n_fill = 16'hFFFE - int'(acc_exp);
    repeat (n_fill) send(2'd0, '0, '0, '0, 4'h0, '0);
    @(negedge clk);
    check("acc_fffe", acc_cnt, 16'hFFFE);
    idle(1);
    repeat (3) send(2'd2, '0, '0, A0, 4'h0, {4'hF, A0});
    @(negedge clk);
    check("acc_sat", acc_cnt, 16'hFFFF);
    idle(3);
    check("acc_sat_hold", acc_cnt, 16'hFFFF);
    check("drain_sat", exp_q.size(), 0);

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    send(2'd0, A0, B0, C0, 4'h0, {4'hF, {4{8'hE8}}});
    send(2'd1, A0, B0, C0, 4'h0, {4'hF, {4{8'hE4}}});
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1'b1);
    @(posedge clk);
    #3;
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, '0);
    check("arst_out_nz", out_nz, '0);
    check("arst_acc", acc_cnt, 16'd0);
    check("arst_in_ready", in_ready, 1'b0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(2'd3, A0, B0, C0, 4'b1000, {4'b0111, 32'h00969696});
    @(negedge clk);
    check("post_rst_lat0", out_valid, 1'b0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_data", out_data, 32'h00969696);
    check("post_rst_acc", acc_cnt, 16'd1);
    idle(3);
    check("drain_final", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
